// File: rtl/serum_pkt_arb_pkg.sv
// serum_pkt_pkg: shared arbiter state, beat layout and counter width for serum_pkt_arb
package serum_pkt_pkg;
   localparam int PKT_DW = 8;
   localparam int PKT_CNT_W = 16;
   typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;
   typedef struct packed {
      logic              last;
      logic [PKT_DW-1:0] data;
   } pkt_beat_t;
endpackage

// File: rtl/serum_pkt_arb_if.sv
// serum_pkt_arb_if: NCH input channels plus one merged output stream
// out_pkt_cnt exists only when SERUM_PKT_CNT_EN is defined
interface serum_pkt_arb_if import serum_pkt_pkg::*; #(
   parameter int NCH = 4,
   parameter int DW  = 8
);
   logic [NCH-1:0]         in_valid;
   logic [NCH-1:0]         in_ready;
   logic [NCH*DW-1:0]      in_data;
   logic [NCH-1:0]         in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [DW-1:0]          out_data;
   logic                   out_last;
   logic [$clog2(NCH)-1:0] out_ch;
`ifdef SERUM_PKT_CNT_EN
   logic [PKT_CNT_W-1:0]   out_pkt_cnt;
   modport master (input in_valid, in_data, in_last, out_ready,
                   output in_ready, out_valid, out_data, out_last, out_ch, out_pkt_cnt);
   modport slave (output in_valid, in_data, in_last, out_ready,
                  input in_ready, out_valid, out_data, out_last, out_ch, out_pkt_cnt);
`else
   modport master (input in_valid, in_data, in_last, out_ready,
                   output in_ready, out_valid, out_data, out_last, out_ch);
   modport slave (output in_valid, in_data, in_last, out_ready,
                  input in_ready, out_valid, out_data, out_last, out_ch);
`endif
endinterface

// File: rtl/serum_pkt_fifo.sv
// serum_pkt_fifo: single-channel FIFO of {last, data}; full/empty come from a registered count
module serum_pkt_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic [DW:0] wdata,
   output logic [DW:0] rdata,
   output logic        full,
   output logic        empty
);
   localparam int AW = $clog2(DEPTH);
   logic [DW:0]   mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];
   always_ff @(posedge clk)
      if (do_push) mem[wptr] <= wdata;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop) rptr <= rptr + 1'b1;
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/serum_pkt_arb.sv
// serum_pkt_arb: per-channel FIFOs merged by a packet-atomic round-robin arbiter
// SERUM_PKT_CNT_EN adds out_pkt_cnt, a wrapping count of completed output packets
module serum_pkt_arb import serum_pkt_pkg::*; #(
   parameter int NCH   = 4,
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input logic             clk,
   input logic             rst,
   serum_pkt_arb_if.master bus
);
   localparam int CW = $clog2(NCH);
   logic [DW:0]    head [NCH];
   logic [NCH-1:0] empty, full, pop;
   arb_state_e     state, state_nx;
   logic [CW-1:0]  rr_ptr, rr_nx, lock_ch, lock_nx, gnt, gnt_inc, idx;
   logic           accept, head_last;
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      serum_pkt_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (bus.in_valid[c]),
         .pop   (pop[c]),
         .wdata ({bus.in_last[c], bus.in_data[c*DW +: DW]}),
         .rdata (head[c]),
         .full  (full[c]),
         .empty (empty[c])
      );
   end
   assign bus.in_ready = ~full;
   // scan downward so the nearest non-empty channel at or after rr_ptr wins
   always_comb begin
      gnt = lock_ch;
      idx = '0;
      if (state == ARB_IDLE)
         for (int i = NCH-1; i >= 0; i--) begin
            idx = CW'((int'(rr_ptr) + i) % NCH);
            if (!empty[idx]) gnt = idx;
         end
   end
   assign gnt_inc       = gnt == CW'(NCH-1) ? '0 : gnt + 1'b1;
   assign head_last     = head[gnt][DW];
   assign bus.out_valid = !empty[gnt];
   assign accept        = bus.out_valid && bus.out_ready;
   assign pop           = {{(NCH-1){1'b0}}, accept} << gnt;
   assign bus.out_data  = bus.out_valid ? head[gnt][DW-1:0] : '0;
   assign bus.out_last  = bus.out_valid && head_last;
   assign bus.out_ch    = bus.out_valid ? gnt : '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= ARB_IDLE;
         rr_ptr  <= '0;
         lock_ch <= '0;
      end else begin
         state   <= state_nx;
         rr_ptr  <= rr_nx;
         lock_ch <= lock_nx;
      end
   always_comb begin
      state_nx = state;
      rr_nx    = rr_ptr;
      lock_nx  = lock_ch;
      if (accept && head_last) begin
         state_nx = ARB_IDLE;
         rr_nx    = gnt_inc;
      end else if (accept && state == ARB_IDLE) begin
         state_nx = ARB_LOCK;
         lock_nx  = gnt;
      end
   end
`ifdef SERUM_PKT_CNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) bus.out_pkt_cnt <= '0;
      else if (accept && head_last) bus.out_pkt_cnt <= bus.out_pkt_cnt + 1'b1;
`endif
endmodule

// File: doc/serum_pkt_arb.md
# serum_pkt_arb

Parametrised N-channel packet aggregator for the serum datapath: each input channel feeds a private FIFO, and a round-robin arbiter merges the FIFOs onto one output stream without interleaving packets. It is the next-generation DUT for the input-agent / output-agent environment. Each `in_*` channel maps to one input agent instance. The single `out_*` stream is checked by the output monitor and scoreboard; `out_ch` identifies the source channel for each beat.

## Interface
- `NCH`, 4: number of input channels, ≥2.
- `DW`, 8: data width per beat.
- `DEPTH`, 8: entries per channel FIFO, power of two, ≥2.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, NCH: per-channel beat valid.
- `in_ready`, out, NCH: per-channel FIFO not full.
- `in_data`, in, NCH*DW: channel c occupies bits [c*DW +: DW].
- `in_last`, in, NCH: marks the final beat of a packet.
- `out_valid`, out, 1: output beat valid.
- `out_ready`, in, 1: sink accepts the beat.
- `out_data`, out, DW: output beat data.
- `out_last`, out, 1: final beat of the output packet.
- `out_ch`, out, $clog2(NCH): source channel of the current beat.
- `out_pkt_cnt`, out, 16: present only with `SERUM_PKT_CNT_EN`.

## Operation
- **Handshakes:** a beat transfers when valid && ready. Valid must not depend on ready. Data and last are held stable while valid && !ready.
- **Push:** each channel pushes {last, data} into its FIFO on an input transfer.
- **`in_ready[c]`:** equals FIFO c not full, from a registered occupancy count of width $clog2(DEPTH)+1.
- **Arbiter states:**
  - IDLE: grant goes to the first non-empty channel at or after `rr_ptr`, scanning upward and wrapping at NCH−1 → 0.
  - LOCK(g): held for the rest of a packet.
- **IDLE transitions:**
  - Accepted beat with last=0: go to LOCK(g).
  - Accepted beat with last=1: stay in IDLE; `rr_ptr` ← g+1 mod NCH.
- **LOCK(g) transitions:**
  - Only channel g is eligible.
  - Accepted beat with last=1: go to IDLE; `rr_ptr` ← g+1 mod NCH.
- **Mid-packet underflow:** if channel g's FIFO empties mid-packet, `out_valid` drops and LOCK(g) is held. Other channels are never interleaved.
- **Output drive:** `out_valid` = granted FIFO non-empty. `out_data`, `out_last`, and `out_ch` come from the granted FIFO head. `out_ch` is 0 whenever `out_valid`=0.
- **Full FIFO:** with `in_ready`=0, a pop in cycle N makes `in_ready` 1 in cycle N+1. A same-cycle push and pop on a non-full FIFO leaves the count unchanged.
- **Wrap-around:** read and write pointers wrap modulo DEPTH. Full vs. empty is decided by the count, not by pointer equality.

## Timing
- **Reset values:**
  - FIFOs empty; `in_ready` all 1.
  - Arbiter in IDLE; `rr_ptr`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_ch`=0, `out_pkt_cnt`=0.
- **Latency:** a beat pushed in cycle N into an empty FIFO with the arbiter free appears on `out_*` in cycle N+1. There is no combinational path from input to output.
- **Throughput:** one beat per cycle with `out_ready`=1. There are no bubbles between back-to-back packets from different channels, because the IDLE grant is combinational from the registered state.
- **Reset mid-packet:** all queued and partial packets are discarded. The first output after reset is a fresh packet.

## Configuration
- **`SERUM_PKT_CNT_EN` defined:**
  - `out_pkt_cnt` port exists.
  - The counter increments by 1 on every accepted beat with `out_last`=1 and wraps 0xFFFF → 0.
  - It resets to 0.
- **Not defined:** neither the port nor the counter logic exists, and behaviour is otherwise identical.

## Structure
- **Package `serum_pkt_pkg`:**
  - Arbiter state enum `arb_state_e` {ARB_IDLE, ARB_LOCK}.
  - Beat struct `pkt_beat_t` {last, data}, parametrised through DW via `localparam`.
  - Counter width constant `PKT_CNT_W`=16.
- **Sub-module `serum_pkt_fifo`:** a single-channel synchronous FIFO (DW+1 wide, DEPTH deep, registered count, full/empty flags). It is instantiated NCH times in a generate loop. Arbiter and output muxing stay in the top level.

## Test plan
- **Single beat:** channel 0 sends a 1-beat packet 0xA5 with `out_ready`=1 → one cycle later `out_valid`=1, `out_data`=0xA5, `out_last`=1, `out_ch`=0.
- **Round-robin order:** all 4 channels each hold one 2-beat packet → output order is channels 0, 1, 2, 3 with 8 consecutive beats and no gaps; the next grant starts at channel 0.
- **No interleaving:** channel 1 sends beat 1 of 3, stalls 5 cycles, then sends the rest, while channel 2 has a packet queued → `out_valid`=0 during the stall and channel 2 is output only after channel 1's `out_last`.
- **Backpressure and full:** `out_ready`=0 while channel 3 pushes 8 beats → `in_ready[3]`=0 after the 8th. Pulsing `out_ready` for one cycle → `in_ready[3]`=1 in the next cycle, and no data is lost or duplicated.
- **Reset mid-packet:** assert `rst` mid-packet with FIFOs partially full → all outputs return to reset values immediately and `in_ready`=all 1.
- **Counter (with `SERUM_PKT_CNT_EN`):** 65537 single-beat packets → `out_pkt_cnt`=1.
